// File: rtl/instructions.sv
// MC14500B instruction set, shared by the ICU and everything that drives it.
package instructions;

   typedef enum logic [3:0] {
      NOPO = 4'h0,
      LD   = 4'h1,
      LDC  = 4'h2,
      AND  = 4'h3,
      ANDC = 4'h4,
      OR   = 4'h5,
      ORC  = 4'h6,
      XNOR = 4'h7,
      STO  = 4'h8,
      STOC = 4'h9,
      IEN  = 4'hA,
      OEN  = 4'hB,
      JMP  = 4'hC,
      RTN  = 4'hD,
      SKZ  = 4'hE,
      NOPF = 4'hF
   } instruction_t;

endpackage

// File: rtl/sequencer_pkg.sv
// Types and constants for the MC14500B run sequencer.
package sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_ACC,
      S_WR,
      S_READY,
      S_START,
      S_RUN,
      S_HALT
   } seq_state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_OVF     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_ABORT   = 2'd3;

   // The ICU is considered finished when it fetches this opcode.
   localparam instructions::instruction_t HALT_OPCODE = instructions::NOPF;

   // ICU reset is held for two cycles before loading; the down-counter
   // starts at one and the last CLR cycle is the one that sees zero.
   localparam logic CLR_TMR_LOAD = 1'b1;

   // Quiescent states are the ones where the host may start a new action.
   function automatic logic is_busy(input seq_state_t s);
      return !(s inside {S_IDLE, S_READY, S_HALT});
   endfunction

   // The ICU is released from reset only while it is being written or run.
   function automatic logic icu_held(input seq_state_t s);
      return !(s inside {S_ACC, S_WR, S_RUN});
   endfunction

endpackage

// File: rtl/mc14500b_sequencer.sv
// Loads a program image into the MC14500B ICU, restarts it, and supervises
// the run until a halt opcode, an abort or the cycle budget ends it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no valid image, waiting for a load
// CLR   | ICU held in reset for two cycles ahead of a load
// ACC   | ready for the next program word
// WR    | write strobe to the ICU for the word just accepted
// READY | complete image resident, waiting for run_req or a new load
// START | one-cycle ICU reset so execution restarts at address 0
// RUN   | ICU executing, cycles counted, halt/timeout watched
// HALT  | run ended, ICU parked in reset, image retained
module mc14500b_sequencer
   import sequencer_pkg::*;
#(
   parameter int          MAX_WORDS  = 256,
   parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [11:0]                ld_data,
   input  logic                       ld_last,
   input  logic                       run_req,
   input  logic                       halt_req,
   output logic                       icu_rst,
   output logic                       icu_write,
   output logic [11:0]                icu_cmd,
   input  instructions::instruction_t icu_opcode,
   output logic                       busy,
   output logic                       loaded,
   output logic                       done,
   output logic [1:0]                 error,
   output logic [8:0]                 word_cnt,
   output logic [15:0]                cycle_cnt
);

   localparam logic [8:0]  WORD_LIMIT = 9'(MAX_WORDS);
   localparam logic [15:0] CYCLE_LAST = MAX_CYCLES - 16'd1;

   seq_state_t  state_q, state_d;
   logic        clr_tmr_q, clr_tmr_d;
   logic        last_q, last_d;
   logic [11:0] cmd_d;
   logic [8:0]  word_cnt_d;
   logic [15:0] cycle_cnt_d;
   logic        loaded_d, done_d;
   logic [1:0]  error_d;

   // Only combinational output; depends on registered state alone.
   assign ld_ready = (state_q == S_ACC);

   // Next-state and next-value decode for the FSM and its counters.
   always_comb begin
      state_d     = state_q;
      clr_tmr_d   = clr_tmr_q;
      last_d      = last_q;
      cmd_d       = icu_cmd;
      word_cnt_d  = word_cnt;
      cycle_cnt_d = cycle_cnt;
      loaded_d    = loaded;
      done_d      = done;
      error_d     = error;

      unique case (state_q)
         S_IDLE, S_READY, S_HALT: begin
            if (ld_valid) begin
               state_d    = S_CLR;
               clr_tmr_d  = CLR_TMR_LOAD;
               loaded_d   = 1'b0;
               error_d    = ERR_NONE;
               done_d     = 1'b0;
               word_cnt_d = '0;
            end else if (run_req && loaded) begin
               state_d     = S_START;
               done_d      = 1'b0;
               error_d     = ERR_NONE;
               cycle_cnt_d = '0;
            end
         end
         S_CLR: begin
            if (halt_req) begin
               state_d  = S_IDLE;
               error_d  = ERR_ABORT;
               loaded_d = 1'b0;
            end else if (clr_tmr_q == 1'b0) begin
               state_d = S_ACC;
            end else begin
               clr_tmr_d = clr_tmr_q - 1'b1;
            end
         end
         S_ACC: begin
            // An abort wins over a word offered in the same cycle; that word is dropped.
            if (halt_req) begin
               state_d  = S_IDLE;
               error_d  = ERR_ABORT;
               loaded_d = 1'b0;
            end else if (ld_valid) begin
               cmd_d      = ld_data;
               word_cnt_d = word_cnt + 9'd1;
               last_d     = ld_last;
               state_d    = S_WR;
            end
         end
         S_WR: begin
            // The strobe for this word is already on the pins and completes regardless.
            if (halt_req) begin
               state_d  = S_IDLE;
               error_d  = ERR_ABORT;
               loaded_d = 1'b0;
            end else if (last_q) begin
               state_d  = S_READY;
               loaded_d = 1'b1;
            end else if (word_cnt == WORD_LIMIT) begin
               state_d = S_IDLE;
               error_d = ERR_OVF;
            end else begin
               state_d = S_ACC;
            end
         end
         S_START: begin
            if (halt_req) begin
               state_d = S_HALT;
               error_d = ERR_ABORT;
               done_d  = 1'b0;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            cycle_cnt_d = cycle_cnt + 16'd1;
            if (halt_req) begin
               state_d = S_HALT;
               error_d = ERR_ABORT;
               done_d  = 1'b0;
            end else if (icu_opcode == HALT_OPCODE) begin
               state_d = S_HALT;
               done_d  = 1'b1;
            end else if (cycle_cnt == CYCLE_LAST) begin
               state_d = S_HALT;
               error_d = ERR_TIMEOUT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counters and all status outputs, registered together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         clr_tmr_q <= 1'b0;
         last_q    <= 1'b0;
         icu_rst   <= 1'b1;
         icu_write <= 1'b0;
         icu_cmd   <= '0;
         busy      <= 1'b0;
         loaded    <= 1'b0;
         done      <= 1'b0;
         error     <= ERR_NONE;
         word_cnt  <= '0;
         cycle_cnt <= '0;
      end else begin
         state_q   <= state_d;
         clr_tmr_q <= clr_tmr_d;
         last_q    <= last_d;
         icu_rst   <= icu_held(state_d);
         icu_write <= (state_d == S_WR);
         icu_cmd   <= cmd_d;
         busy      <= is_busy(state_d);
         loaded    <= loaded_d;
         done      <= done_d;
         error     <= error_d;
         word_cnt  <= word_cnt_d;
         cycle_cnt <= cycle_cnt_d;
      end
   end

endmodule

// File: tb/tb_mc14500b_sequencer.sv
// Directed bench for mc14500b_sequencer with a small behavioural ICU.
module tb_mc14500b_sequencer;
   import instructions::*;

   localparam int          TB_MAX_CYC = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ld_valid = 1'b0, ld_last = 1'b0, run_req = 1'b0, halt_req = 1'b0;
   logic [11:0] ld_data = '0;
   logic        ld_ready, icu_rst, icu_write, busy, loaded, done;
   logic [11:0] icu_cmd;
   logic [1:0]  error;
   logic [8:0]  word_cnt;
   logic [15:0] cycle_cnt;
   instruction_t icu_opcode;

   logic        o_ld_valid = 1'b0;
   logic [11:0] o_ld_data = 12'h100;
   logic        o_ld_ready, o_icu_rst, o_icu_write, o_busy, o_loaded, o_done;
   logic [11:0] o_icu_cmd;
   logic [1:0]  o_error;
   logic [8:0]  o_word_cnt;
   logic [15:0] o_cycle_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mc14500b_sequencer #(.MAX_WORDS(256), .MAX_CYCLES(16'(TB_MAX_CYC))) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_data(ld_data), .ld_last(ld_last), .run_req(run_req), .halt_req(halt_req),
      .icu_rst(icu_rst), .icu_write(icu_write), .icu_cmd(icu_cmd),
      .icu_opcode(icu_opcode), .busy(busy), .loaded(loaded), .done(done),
      .error(error), .word_cnt(word_cnt), .cycle_cnt(cycle_cnt));

   mc14500b_sequencer #(.MAX_WORDS(4), .MAX_CYCLES(16'd1000)) dut_ovf (
      .clk(clk), .rst(rst), .ld_valid(o_ld_valid), .ld_ready(o_ld_ready),
      .ld_data(o_ld_data), .ld_last(1'b0), .run_req(1'b0), .halt_req(1'b0),
      .icu_rst(o_icu_rst), .icu_write(o_icu_write), .icu_cmd(o_icu_cmd),
      .icu_opcode(NOPO), .busy(o_busy), .loaded(o_loaded), .done(o_done),
      .error(o_error), .word_cnt(o_word_cnt), .cycle_cnt(o_cycle_cnt));

   // Behavioural ICU: sequential program write, PC restart on reset, JMP.
   logic [11:0] mem [256];
   logic [7:0]  pc = '0, wp = '0;
   assign icu_opcode = instruction_t'(mem[pc][11:8]);

   always @(posedge clk) begin
      if (icu_rst) begin
         pc <= '0;
         wp <= '0;
      end else begin
         if (icu_write) begin
            mem[wp] <= icu_cmd;
            wp      <= wp + 8'd1;
         end
         if (icu_opcode == JMP) pc <= mem[pc][7:0];
         else                   pc <= pc + 8'd1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard of words the ICU must see, in order.
   logic [11:0] sb_q [$];
   int  tb_cyc = 0, wr_cnt = 0, first_wr = 0, last_wr = 0, o_wr_cnt = 0;
   logic prev_wr = 1'b0;

   always @(negedge clk) begin
      tb_cyc++;
      if (rst && icu_write) begin
         if (wr_cnt == 0) first_wr = tb_cyc;
         last_wr = tb_cyc;
         wr_cnt++;
         chk("wr_consecutive", 32'(prev_wr), 0);
         if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL wr_unexpected: observed cmd %0h expected no write", icu_cmd);
         end else begin
            chk("icu_cmd", 32'(icu_cmd), 32'(sb_q.pop_front()));
         end
      end
      prev_wr = icu_write;
      if (o_icu_write) o_wr_cnt++;
   end

   logic [11:0] prog [16];
   int          prog_n;

   task automatic set_loop_prog();
      prog[0] = 12'h6FF; prog[1] = 12'hAFF; prog[2] = 12'hBFF; prog[3] = 12'h800;
      prog[4] = 12'h700; prog[5] = 12'h2FF; prog[6] = 12'h800; prog[7] = 12'h801;
      prog[8] = 12'h802; prog[9] = 12'hC05;
      prog_n = 10;
   endtask

   task automatic set_halt_prog();
      prog[0] = 12'h100; prog[1] = 12'h800; prog[2] = 12'h200; prog[3] = 12'h900;
      prog[4] = 12'hF00;
      prog_n = 5;
   endtask

   // Reference execution: RUN cycles until NOPF or the budget runs out.
   task automatic model_run(output int cyc, output bit dn);
      int pc_m = 0;
      logic [11:0] w;
      cyc = 0;
      dn  = 1'b0;
      for (int c = 1; c <= TB_MAX_CYC; c++) begin
         w   = (pc_m < prog_n) ? prog[pc_m] : 12'h000;
         cyc = c;
         if (w[11:8] == 4'hF) begin dn = 1'b1; return; end
         pc_m = (w[11:8] == 4'hC) ? int'(w[7:0]) : pc_m + 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int abort_at, input bit with_run);
      int k;
      wr_cnt   = 0;
      ld_valid = 1'b1;
      ld_data  = prog[0];
      ld_last  = (prog_n == 1);
      run_req  = with_run;
      step();
      run_req  = 1'b0;
      if (with_run) begin
         chk("simul_loaded", 32'(loaded), 0);
         chk("simul_icu_rst", 32'(icu_rst), 1);
         step();
         step();
         chk("simul_ready", 32'(ld_ready), 1);
      end
      for (int i = 0; i < prog_n; i++) begin
         ld_data  = prog[i];
         ld_last  = (i == prog_n - 1);
         ld_valid = 1'b1;
         k = 0;
         while (!ld_ready && k < 10) begin step(); k++; end
         chk("ld_ready_wait", 32'(ld_ready), 1);
         if (!ld_ready) break;
         sb_q.push_back(prog[i]);
         step();
         ld_valid = 1'b0;
         ld_last  = 1'b0;
         if (i == abort_at) begin
            halt_req = 1'b1;
            step();
            halt_req = 1'b0;
            return;
         end
      end
      step();
   endtask

   task automatic check_loaded();
      chk("ld_word_cnt", 32'(word_cnt), prog_n);
      chk("ld_loaded", 32'(loaded), 1);
      chk("ld_busy", 32'(busy), 0);
      chk("ld_error", 32'(error), 0);
      chk("ld_ready_off", 32'(ld_ready), 0);
      chk("ld_writes", wr_cnt, prog_n);
      chk("ld_spacing", last_wr - first_wr, 2 * (prog_n - 1));
      chk("ld_sb_empty", sb_q.size(), 0);
   endtask

   task automatic run_prog(input int exp_cyc, input bit exp_done, input logic [1:0] exp_err);
      int k;
      run_req = 1'b1;
      step();
      run_req = 1'b0;
      chk("start_icu_rst", 32'(icu_rst), 1);
      chk("start_busy", 32'(busy), 1);
      step();
      chk("run_icu_rst", 32'(icu_rst), 0);
      k = 0;
      while (icu_rst == 1'b0 && k < 200) begin k++; step(); end
      chk("run_len", k, exp_cyc);
      chk("run_done", 32'(done), 32'(exp_done));
      chk("run_error", 32'(error), 32'(exp_err));
      chk("run_cycle_cnt", 32'(cycle_cnt), exp_cyc);
      chk("run_busy", 32'(busy), 0);
      chk("run_loaded", 32'(loaded), 1);
      step();
      step();
      chk("halt_cnt_frozen", 32'(cycle_cnt), exp_cyc);
      chk("halt_icu_rst", 32'(icu_rst), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int  exp_cyc;
      bit  exp_dn;
      int  hs;
      logic rdy;

      // Reset values on both instances.
      repeat (3) step();
      chk("rst_icu_rst", 32'(icu_rst), 1);
      chk("rst_icu_write", 32'(icu_write), 0);
      chk("rst_ld_ready", 32'(ld_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_loaded", 32'(loaded), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_ovf_icu_rst", 32'(o_icu_rst), 1);
      rst = 1'b1;
      step();

      // 10-word image, then run it: it loops forever and must time out.
      set_loop_prog();
      load(-1, 1'b0);
      check_loaded();
      model_run(exp_cyc, exp_dn);
      run_prog(exp_cyc, exp_dn, exp_dn ? 2'd0 : 2'd2);

      // Rerun of the same image, aborted mid-run.
      run_req = 1'b1;
      step();
      run_req = 1'b0;
      step();
      repeat (3) step();
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      chk("abort_run_error", 32'(error), 3);
      chk("abort_run_done", 32'(done), 0);
      chk("abort_run_loaded", 32'(loaded), 1);
      chk("abort_run_icu_rst", 32'(icu_rst), 1);
      chk("abort_run_cnt", 32'(cycle_cnt), 4);

      // Image ending in NOPF: run, then rerun with the same count.
      set_halt_prog();
      load(-1, 1'b0);
      check_loaded();
      model_run(exp_cyc, exp_dn);
      run_prog(exp_cyc, exp_dn, 2'd0);
      run_prog(exp_cyc, exp_dn, 2'd0);

      // Abort during the third word of a load.
      set_loop_prog();
      load(2, 1'b0);
      chk("abort_ld_error", 32'(error), 3);
      chk("abort_ld_loaded", 32'(loaded), 0);
      chk("abort_ld_busy", 32'(busy), 0);
      chk("abort_ld_writes", wr_cnt, 3);
      chk("abort_ld_sb", sb_q.size(), 0);

      // Load then simultaneous ld_valid + run_req from READY.
      set_halt_prog();
      load(-1, 1'b0);
      check_loaded();
      load(-1, 1'b1);
      check_loaded();

      // Synchronous reset in the middle of a run.
      run_req = 1'b1;
      step();
      run_req = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      chk("mid_rst_icu_rst", 32'(icu_rst), 1);
      chk("mid_rst_icu_write", 32'(icu_write), 0);
      chk("mid_rst_icu_cmd", 32'(icu_cmd), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_loaded", 32'(loaded), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_error", 32'(error), 0);
      chk("mid_rst_word_cnt", 32'(word_cnt), 0);
      chk("mid_rst_cycle_cnt", 32'(cycle_cnt), 0);
      rst = 1'b1;
      step();

      // Overflow: stream words without ld_last into a 4-word instance.
      o_ld_valid = 1'b1;
      hs = 0;
      for (int c = 0; c < 40 && hs < 4; c++) begin
         rdy = o_ld_ready;
         step();
         if (rdy) begin
            hs++;
            o_ld_data = o_ld_data + 12'd1;
         end
      end
      o_ld_valid = 1'b0;
      chk("ovf_handshakes", hs, 4);
      step();
      chk("ovf_error", 32'(o_error), 1);
      chk("ovf_loaded", 32'(o_loaded), 0);
      chk("ovf_ld_ready", 32'(o_ld_ready), 0);
      chk("ovf_busy", 32'(o_busy), 0);
      chk("ovf_word_cnt", 32'(o_word_cnt), 4);
      chk("ovf_writes", o_wr_cnt, 4);
      step();
      chk("ovf_stays_idle", 32'(o_busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mc14500b_sequencer.md
# mc14500b_sequencer

Run controller for the MC14500B ICU. Accepts a program image over a valid/ready word stream and writes it into the ICU using the ICU's program-write strobe protocol. It then pulses the ICU reset to restart execution at address 0, runs until a halt opcode, abort or cycle timeout, and reports status. It sits between the host/loader fabric and the MC14500B instance, and is the only driver of the ICU's `rst`, `program_write` and `program_cmd` inputs.

## Interface
- `MAX_WORDS`, 256: program depth; words accepted before overflow.
- `MAX_CYCLES`, 16'd1000: run-cycle budget before timeout.
- `clk  in  1`: single clock.
- `rst  in  1`: synchronous, active-low reset.
- `ld_valid  in  1`: program word valid.
- `ld_ready  out  1`: sequencer accepts word this cycle.
- `ld_data  in  12`: program word, {opcode[3:0], addr[7:0]}.
- `ld_last  in  1`: qualifies the final word of the image.
- `run_req  in  1`: start execution; single-cycle pulse.
- `halt_req  in  1`: abort the current load or run.
- `icu_rst  out  1`: active-high reset to the ICU.
- `icu_write  out  1`: ICU program-write strobe.
- `icu_cmd  out  12`: ICU program word.
- `icu_opcode  in  instruction_t`: opcode currently executing in the ICU.
- `busy  out  1`: state is not IDLE, READY or HALT.
- `loaded  out  1`: a complete image is resident.
- `done  out  1`: the last run ended by halt opcode.
- `error  out  2`: 0 none, 1 overflow, 2 timeout, 3 abort.
- `word_cnt  out  9`: words written in the current or last load.
- `cycle_cnt  out  16`: RUN cycles in the current or last run.

## Operation
- States: IDLE, CLR, ACC, WR, READY, START, RUN, HALT.
- Reset values:
  - `icu_rst`=1; all other outputs 0.
  - State IDLE; `loaded` cleared.
- IDLE/READY/HALT:
  - `ld_valid`=1 → CLR; clears `loaded`, `error`, `done`, `word_cnt`.
  - Otherwise `run_req`=1 with `loaded`=1 → START; clears `done`, `error`, `cycle_cnt`.
  - `run_req` with `loaded`=0 is ignored.
  - `ld_valid` wins over a simultaneous `run_req`.
- CLR: `icu_rst`=1 for exactly 2 cycles, then ACC.
- ACC:
  - `icu_rst`=0, `ld_ready`=1.
  - On handshake: register `ld_data` into `icu_cmd`, `word_cnt`++, → WR.
- WR:
  - `icu_write`=1, `ld_ready`=0.
  - Then → READY if the accepted word had `ld_last`, setting `loaded`=1.
  - Else, if `word_cnt`==`MAX_WORDS` → IDLE with `error`=1.
  - Else → ACC.
- START: `icu_rst`=1 for 1 cycle, then RUN.
- RUN:
  - `icu_rst`=0; `cycle_cnt`++ each cycle.
  - `icu_opcode`==NOPF (4'hF) → HALT, `done`=1.
  - Else `cycle_cnt`==`MAX_CYCLES`-1 → HALT, `error`=2.
- HALT: `icu_rst`=1 held; counters frozen; image retained, so `run_req` reruns it.
- `halt_req` in CLR/ACC/WR:
  - → IDLE, `error`=3, `loaded`=0.
  - A write strobe already in WR still completes that cycle.
- `halt_req` in START/RUN: → HALT, `error`=3, `done`=0.
- `halt_req` priority: above halt-opcode detection and timeout in the same cycle.

## Timing
- Load handshake:
  - Handshake in cycle N → `icu_write`=1 with stable `icu_cmd` in N+1.
  - `ld_ready` returns in N+2.
  - `icu_write` is never high on two consecutive cycles.
  - Maximum rate is 1 word per 2 cycles.
- `icu_cmd` holds its value after the strobe until the next accepted word.
- Run start latency:
  - `run_req` in cycle N → `icu_rst`=1 in N+1 (START).
  - `icu_rst`=0 from N+2 (first RUN cycle, `cycle_cnt`=1 at end).
- Halt latency: NOPF seen in cycle M → HALT, `icu_rst`=1 and `done`=1 in M+1.
- Status outputs are registered; no combinational paths except `ld_ready` (decoded from registered state).
- `rst` low mid-load or mid-run: next edge returns all outputs to reset values and clears `loaded`.

## Structure
- Package `sequencer_pkg` holds:
  - `seq_state_t` enum.
  - Error code constants `ERR_NONE`/`ERR_OVF`/`ERR_TIMEOUT`/`ERR_ABORT`.
  - Halt opcode constant built on `instructions::instruction_t` (NOPF).
- `instruction_t` is imported from the existing `instructions` package, not redeclared.
- Single module; no sub-module. The FSM, word counter and cycle counter fit in one block.

## Test plan
- Load 10 words (6FF, AFF, BFF, 800, 700, 2FF, 800, 801, 802, C05, last on C05):
  - 10 `icu_write` pulses, each with the matching `icu_cmd`, 2 cycles apart.
  - `word_cnt`=10, `loaded`=1, state READY.
- Load a program ending in F00, then `run_req`:
  - `icu_rst` high 1 cycle, then low.
  - On NOPF: `done`=1, `icu_rst`=1, `cycle_cnt` frozen.
  - A second `run_req` reruns with identical `cycle_cnt`.
- Load the looping program (C05 with no NOPF) and run with `MAX_CYCLES`=20:
  - HALT after exactly 20 RUN cycles, `error`=2, `done`=0.
- Stream `MAX_WORDS`=4 words without `ld_last`:
  - 4 writes, then IDLE, `error`=1, `loaded`=0, `ld_ready`=0.
- `halt_req` during word 3 of a load, and separately mid-run:
  - Load case: IDLE, `error`=3, `loaded`=0.
  - Run case: HALT, `error`=3, `loaded` still 1.
- `rst` low during RUN; `ld_valid` and `run_req` asserted together in READY:
  - `rst` low: all outputs at reset values on the next edge.
  - Simultaneous request: the load path (CLR) is taken.
